// File: rtl/seq_booth_multiplier_pkg.sv
// Shared ALU definitions for the sequential Booth multiplier: widths, FSM state encoding
// and the radix-2 Booth operation decode.
package seq_booth_multiplier_pkg;

    localparam int unsigned MULT_WIDTH = 32;
    localparam int unsigned MULT_ITER  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mult_state_e;

    typedef enum logic [1:0] {
        NOP = 2'b00,
        ADD = 2'b01,
        SUB = 2'b10
    } booth_op_e;

    // Radix-2 Booth recoding of the current multiplier bit pair {P[1], P[0]}.
    function automatic booth_op_e booth_decode(input logic [1:0] bits);
        booth_op_e op;
        case (bits)
            2'b01:   op = ADD;
            2'b10:   op = SUB;
            default: op = NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/carry_select_Adder.sv
// 32-bit carry-select adder built from four 8-bit blocks, each precomputing both carry-in
// outcomes.
module carry_select_Adder
    import seq_booth_multiplier_pkg::*;
(
    input  logic [MULT_WIDTH-1:0] a,
    input  logic [MULT_WIDTH-1:0] b,
    input  logic                  cin,
    output logic [MULT_WIDTH-1:0] sum,
    output logic                  cout
);

    localparam int unsigned BLK  = 8;
    localparam int unsigned NBLK = MULT_WIDTH / BLK;

    logic [NBLK:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        logic [BLK:0] s0;
        logic [BLK:0] s1;

        assign s0 = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]};
        assign s1 = s0 + {{BLK{1'b0}}, 1'b1};

        assign sum[i*BLK +: BLK] = carry[i] ? s1[BLK-1:0] : s0[BLK-1:0];
        assign carry[i+1]        = carry[i] ? s1[BLK]     : s0[BLK];
    end

    assign cout = carry[NBLK];

endmodule

// File: rtl/seq_booth_multiplier.sv
// Multi-cycle signed 32x32 radix-2 Booth multiplier, one step per clock.
// Optional MULT_HI_OUT_EN exposes the high product word on out_hi.
module seq_booth_multiplier
    import seq_booth_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter int unsigned ITER  = MULT_ITER
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    output logic             busy,
    output logic             data_resultRDY,
    output logic [WIDTH-1:0] out,
    output logic             data_exception
`ifdef MULT_HI_OUT_EN
    ,
    output logic [WIDTH-1:0] out_hi
`endif
);

    localparam int unsigned CNT_W = $clog2(ITER);

    mult_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [2*WIDTH:0] p_q, p_d;
    logic [WIDTH-1:0] out_q;
    logic             exc_q;

    booth_op_e        op;
    logic [WIDTH-1:0] add_a, add_b, add_sum, upper;
    logic             add_cin, ovf, shift_in, final_step;
    logic             adder_cout_unused;
    logic [2*WIDTH:0] p_step;

    assign op      = booth_decode(p_q[1:0]);
    assign add_a   = p_q[2*WIDTH:WIDTH+1];
    assign add_b   = (op == SUB) ? ~m_q : m_q;
    assign add_cin = (op == SUB);

    carry_select_Adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (adder_cout_unused)
    );

    // Correcting the sign bit by the overflow keeps the 65-bit shift exact when |M| = 2^31.
    assign ovf      = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != add_a[WIDTH-1]);
    assign upper    = (op == NOP) ? add_a : add_sum;
    assign shift_in = (op == NOP) ? p_q[2*WIDTH] : (add_sum[WIDTH-1] ^ ovf);
    assign p_step   = {shift_in, upper, p_q[WIDTH:1]};

    assign final_step = (state_q == RUN) && (cnt_q == CNT_W'(ITER - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        p_d     = p_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (ctrl_MULT) begin
                    state_d = RUN;
                    m_d     = in_A;
                    p_d     = {{WIDTH{1'b0}}, in_B, 1'b0};
                    cnt_d   = '0;
                end
            end
            RUN: begin
                p_d   = p_step;
                cnt_d = cnt_q + 1'b1;
                if (final_step) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            p_q     <= '0;
            out_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            p_q     <= p_d;
            if (final_step) begin
                out_q <= p_step[WIDTH:1];
                exc_q <= p_step[2*WIDTH:WIDTH+1] != {WIDTH{p_step[WIDTH]}};
            end
        end
    end

`ifdef MULT_HI_OUT_EN
    logic [WIDTH-1:0] hi_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q <= '0;
        end else if (final_step) begin
            hi_q <= p_step[2*WIDTH:WIDTH+1];
        end
    end

    assign out_hi = hi_q;
`else
    // High word only feeds exc_q when out_hi is not exported.
`endif

    assign busy           = (state_q == RUN);
    assign data_resultRDY = (state_q == DONE);
    assign out            = out_q;
    assign data_exception = exc_q;

endmodule
